// File: rtl/instruction_decode_stage_pkg.sv
// Shared decode constants for the ID stage: opcodes, functs, width codes, ALU B-source codes.
package instruction_decode_stage_pkg;
    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDI     = 6'h08;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LH       = 6'h21;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SH       = 6'h29;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_MUL  = 6'h02;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    localparam logic [1:0] SRC1_REG  = 2'b00;
    localparam logic [1:0] SRC1_IMM  = 2'b01;
    localparam logic [1:0] SRC1_ZERO = 2'b10;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction
endpackage

// File: rtl/instruction_decode_stage_regfile.sv
// 32x32 GPR file, two async reads, one write, synchronous active-low clear.
// Optional same-cycle write-to-read forwarding under ID_REGFILE_BYPASS_EN.
module id_register_file (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);
    logic [31:0] mem_q [32];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) mem_q[i] <= '0;
        end else if (we_i && waddr_i != 5'd0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 5'd0) return '0;
`ifdef ID_REGFILE_BYPASS_EN
        if (we_i && a == waddr_i) return wdata_i;
`endif
        return mem_q[a];
    endfunction

    assign rdata1_o = rd(raddr1_i);
    assign rdata2_o = rd(raddr2_i);
endmodule

// File: rtl/instruction_decode_stage.sv
// MIPS-subset ID stage: control decode, immediate extension and GPR file.
// Build option ID_REGFILE_BYPASS_EN enables same-cycle WB forwarding in the register file.
module instruction_decode_stage
    import instruction_decode_stage_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic [31:0] Instruction,
    input  logic [4:0]  rDestSelected,
    input  logic [31:0] regWriteData,
    input  logic        RegWrite,
    output logic        PCSel,
    output logic        RegDst,
    output logic        ALUSrc0,
    output logic [1:0]  ALUSrc1,
    output logic        R_Enable,
    output logic        W_Enable,
    output logic [1:0]  R_Width,
    output logic [1:0]  W_Width,
    output logic        MemToReg,
    output logic        RegWriteOut,
    output logic        BranchSel,
    output logic [31:0] Reg_Data1,
    output logic [31:0] Reg_Data2,
    output logic [31:0] Imm32b
);
    logic [5:0]  op, funct;
    logic [4:0]  rt;
    logic [15:0] imm16;

    assign op    = Instruction[31:26];
    assign rt    = Instruction[20:16];
    assign funct = Instruction[5:0];
    assign imm16 = Instruction[15:0];

    id_register_file u_rf (
        .clk_i    (Clock),
        .rst_ni   (Reset),
        .we_i     (RegWrite),
        .waddr_i  (rDestSelected),
        .wdata_i  (regWriteData),
        .raddr1_i (Instruction[25:21]),
        .raddr2_i (rt),
        .rdata1_o (Reg_Data1),
        .rdata2_o (Reg_Data2)
    );

    always_comb begin
        PCSel       = 1'b0;
        RegDst      = 1'b0;
        ALUSrc0     = 1'b0;
        ALUSrc1     = SRC1_REG;
        R_Enable    = 1'b0;
        W_Enable    = 1'b0;
        R_Width     = W_WORD;
        W_Width     = W_WORD;
        MemToReg    = 1'b0;
        RegWriteOut = 1'b0;
        BranchSel   = 1'b0;
        case (op)
            OP_RTYPE: begin
                // The all-zero word is a nop, not sll $0,$0,0
                if (Instruction != 32'h0) begin
                    case (funct)
                        FN_ADD, FN_ADDU, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_XOR, FN_SLT: begin
                            RegDst = 1'b1; RegWriteOut = 1'b1;
                        end
                        FN_SLL, FN_SRL, FN_SRA: begin
                            RegDst = 1'b1; RegWriteOut = 1'b1; ALUSrc0 = 1'b1;
                        end
                        FN_JR: begin
                            RegDst = 1'b1; PCSel = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            OP_SPECIAL2: if (funct == FN_MUL) begin
                RegDst = 1'b1; RegWriteOut = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ALUSrc1 = SRC1_IMM; RegWriteOut = 1'b1;
            end
            OP_LW, OP_LH, OP_LB: begin
                R_Enable = 1'b1; MemToReg = 1'b1; ALUSrc1 = SRC1_IMM; RegWriteOut = 1'b1;
                R_Width  = (op == OP_LW) ? W_WORD : (op == OP_LH) ? W_HALF : W_BYTE;
            end
            OP_SW, OP_SH, OP_SB: begin
                W_Enable = 1'b1; ALUSrc1 = SRC1_IMM;
                W_Width  = (op == OP_SW) ? W_WORD : (op == OP_SH) ? W_HALF : W_BYTE;
            end
            OP_BEQ, OP_BNE: BranchSel = 1'b1;
            OP_BLEZ, OP_BGTZ: begin
                BranchSel = 1'b1; ALUSrc1 = SRC1_ZERO;
            end
            OP_REGIMM: if (rt == 5'd0 || rt == 5'd1) begin
                BranchSel = 1'b1; ALUSrc1 = SRC1_ZERO;
            end
            OP_J: PCSel = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        Imm32b = sext16(imm16);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: Imm32b = {16'h0, imm16};
            OP_LUI:                   Imm32b = {imm16, 16'h0};
            OP_J:                     Imm32b = {6'b0, Instruction[25:0]};
            default: ;
        endcase
    end
endmodule

// File: tb/tb_instruction_decode_stage.sv
// Directed self-checking bench for instruction_decode_stage.
module tb_instruction_decode_stage;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Instruction;
    logic [4:0]  rDestSelected;
    logic [31:0] regWriteData;
    logic        RegWrite;
    logic        PCSel, RegDst, ALUSrc0, R_Enable, W_Enable, MemToReg, RegWriteOut, BranchSel;
    logic [1:0]  ALUSrc1, R_Width, W_Width;
    logic [31:0] Reg_Data1, Reg_Data2, Imm32b;

    int checks = 0;
    int errors = 0;

    instruction_decode_stage dut (
        .Clock(Clock), .Reset(Reset), .Instruction(Instruction),
        .rDestSelected(rDestSelected), .regWriteData(regWriteData), .RegWrite(RegWrite),
        .PCSel(PCSel), .RegDst(RegDst), .ALUSrc0(ALUSrc0), .ALUSrc1(ALUSrc1),
        .R_Enable(R_Enable), .W_Enable(W_Enable), .R_Width(R_Width), .W_Width(W_Width),
        .MemToReg(MemToReg), .RegWriteOut(RegWriteOut), .BranchSel(BranchSel),
        .Reg_Data1(Reg_Data1), .Reg_Data2(Reg_Data2), .Imm32b(Imm32b)
    );

    always #5 Clock = ~Clock;

    // {PCSel,RegDst,ALUSrc0,ALUSrc1,R_Enable,W_Enable,R_Width,W_Width,MemToReg,RegWriteOut,BranchSel}
    logic [13:0] ctrl;
    assign ctrl = {PCSel, RegDst, ALUSrc0, ALUSrc1, R_Enable, W_Enable,
                   R_Width, W_Width, MemToReg, RegWriteOut, BranchSel};

    function automatic logic [13:0] ctl(input bit pc, input bit rd, input bit a0, input bit [1:0] a1,
                                        input bit re, input bit we, input bit [1:0] rw,
                                        input bit [1:0] ww, input bit m2r, input bit rwo, input bit br);
        return {pc, rd, a0, a1, re, we, rw, ww, m2r, rwo, br};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        rDestSelected = a; regWriteData = d; RegWrite = 1'b1;
        tick();
        RegWrite = 1'b0;
    endtask

    task automatic setins(input logic [31:0] ins);
        Instruction = ins;
        #1;
    endtask

    initial begin
        Reset = 1'b0; RegWrite = 1'b0; rDestSelected = '0; regWriteData = '0;
        Instruction = 32'h0;
        tick();
        Reset = 1'b1;
        #1;
        chk("nop_ctrl", 32'(ctrl), 32'(ctl(0,0,0,0,0,0,0,0,0,0,0)));

        setins(32'h01098020);
        chk("rst_rd1", Reg_Data1, 32'd0);
        chk("rst_rd2", Reg_Data2, 32'd0);

        wr(5'd8, 32'd5);
        wr(5'd9, 32'd7);
        setins(32'h01098020);
        chk("add_rd1", Reg_Data1, 32'd5);
        chk("add_rd2", Reg_Data2, 32'd7);
        chk("add_ctrl", 32'(ctrl), 32'(ctl(0,1,0,0,0,0,0,0,0,1,0)));

        setins(32'h2151001A);
        chk("addi_ctrl", 32'(ctrl), 32'(ctl(0,0,0,1,0,0,0,0,0,1,0)));
        chk("addi_imm", Imm32b, 32'h0000001A);
        setins(32'h2151FFF6);
        chk("addi_neg_imm", Imm32b, 32'hFFFFFFF6);
        setins(32'h3151FFF6);
        chk("andi_imm", Imm32b, 32'h0000FFF6);
        setins(32'h3C011234);
        chk("lui_imm", Imm32b, 32'h12340000);

        setins(32'h8E140000);
        chk("lw_ctrl", 32'(ctrl), 32'(ctl(0,0,0,1,1,0,0,0,1,1,0)));
        chk("lw_imm", Imm32b, 32'h0);
        setins(32'hAE140004);
        chk("sw_ctrl", 32'(ctrl), 32'(ctl(0,0,0,1,0,1,0,0,0,0,0)));
        setins(32'h86140002);
        chk("lh_ctrl", 32'(ctrl), 32'(ctl(0,0,0,1,1,0,1,0,1,1,0)));
        setins(32'hA2140001);
        chk("sb_ctrl", 32'(ctrl), 32'(ctl(0,0,0,1,0,1,0,2,0,0,0)));

        setins(32'h72119802);
        chk("mul_ctrl", 32'(ctrl), 32'(ctl(0,1,0,0,0,0,0,0,0,1,0)));
        setins(32'h02119022);
        chk("sub_ctrl", 32'(ctrl), 32'(ctl(0,1,0,0,0,0,0,0,0,1,0)));
        setins(32'h00101100);
        chk("sll_ctrl", 32'(ctrl), 32'(ctl(0,1,1,0,0,0,0,0,0,1,0)));
        setins(32'h03E00008);
        chk("jr_ctrl", 32'(ctrl), 32'(ctl(1,1,0,0,0,0,0,0,0,0,0)));

        setins(32'h1211000A);
        chk("beq_ctrl", 32'(ctrl), 32'(ctl(0,0,0,0,0,0,0,0,0,0,1)));
        setins(32'h1A000003);
        chk("blez_ctrl", 32'(ctrl), 32'(ctl(0,0,0,2,0,0,0,0,0,0,1)));
        setins(32'h0600FFFF);
        chk("bltz_ctrl", 32'(ctrl), 32'(ctl(0,0,0,2,0,0,0,0,0,0,1)));
        chk("bltz_imm", Imm32b, 32'hFFFFFFFF);

        setins(32'h0BFFFFFF);
        chk("j_ctrl", 32'(ctrl), 32'(ctl(1,0,0,0,0,0,0,0,0,0,0)));
        chk("j_imm", Imm32b, 32'h03FFFFFF);
        setins(32'hFC000000);
        chk("bad_op_ctrl", 32'(ctrl), 32'(ctl(0,0,0,0,0,0,0,0,0,0,0)));

        wr(5'd0, 32'h0000FFFF);
        setins(32'h00001020);
        chk("r0_read", Reg_Data1, 32'd0);

        setins(32'h8E140000);
        rDestSelected = 5'd16; regWriteData = 32'd3; RegWrite = 1'b1;
        #1;
`ifdef ID_REGFILE_BYPASS_EN
        chk("same_cycle_rd", Reg_Data1, 32'd3);
`else
        chk("same_cycle_rd", Reg_Data1, 32'd0);
`endif
        tick();
        RegWrite = 1'b0;
        #1;
        chk("after_edge_rd", Reg_Data1, 32'd3);

        setins(32'h01098020);
        rDestSelected = 5'd8; regWriteData = 32'd99; RegWrite = 1'b1; Reset = 1'b0;
        tick();
        Reset = 1'b1; RegWrite = 1'b0;
        #1;
        chk("reset_wins_rd1", Reg_Data1, 32'd0);
        chk("reset_clr_rd2", Reg_Data2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
